// File: rtl/bufer_if_id_skid.sv
// bufer_if_id_skid
//   IF/ID pipeline register with valid/ready handshaking and a 2-entry skid
//   buffer (main output entry plus one skid entry). Carries the fetch PC+4 and
//   the instruction from IF to ID. Supports a hazard-unit stall, a branch
//   flush that injects a NOP bubble, and a saturating count of the valid
//   fetches thrown away by flushes.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. Input side: en_valid & en_ready. Output side: sal_valid & sal_ready
//   & ~stall (stall acts exactly like sal_ready=0). Neither valid waits on its
//   own ready, and en_valid need not be held while en_ready=0.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en_valid/en_ready IF-side handshake (en_ready is registered)
//   EnAdd, EnInsM     PC+4 and instruction from IF
//   stall, flush      hazard-unit hold of ID, branch/jump discard
//   sal_ready         ID can consume
//   sal_valid         SalBuf/SalInst carry a real fetch
//   SalBuf, SalInst   PC+4 and instruction to ID (SalInst=INST_NOP when idle)
//   ocupacion         entries held, 0..2
//   cnt_desc          saturating count of valid fetches discarded by flush
module bufer_if_id_skid #(
  parameter int                    ANCHO_DIR  = 32,
  parameter int                    ANCHO_INST = 32,
  parameter logic [ANCHO_INST-1:0] INST_NOP   = '0,
  parameter int                    ANCHO_CNT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_valid,
  output logic                  en_ready,
  input  logic [ANCHO_DIR-1:0]  EnAdd,
  input  logic [ANCHO_INST-1:0] EnInsM,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  sal_ready,
  output logic                  sal_valid,
  output logic [ANCHO_DIR-1:0]  SalBuf,
  output logic [ANCHO_INST-1:0] SalInst,
  output logic [1:0]            ocupacion,
  output logic [ANCHO_CNT-1:0]  cnt_desc
);

  logic                  main_valid, skid_valid;
  logic [ANCHO_DIR-1:0]  main_addr, skid_addr;
  logic [ANCHO_INST-1:0] main_inst, skid_inst;

  logic                  main_valid_n, skid_valid_n;
  logic [ANCHO_DIR-1:0]  main_addr_n, skid_addr_n;
  logic [ANCHO_INST-1:0] main_inst_n, skid_inst_n;
  logic [ANCHO_CNT-1:0]  cnt_n;

  logic                  in_xfer, out_xfer;
  logic [1:0]            n_disc;
  logic [ANCHO_CNT+1:0]  cnt_sum;

  localparam logic [ANCHO_CNT+1:0] CNT_MAX = {2'b00, {ANCHO_CNT{1'b1}}};

  assign in_xfer  = en_valid & en_ready;
  assign out_xfer = main_valid & sal_ready & ~stall;

  // Entries lost to a flush: a held main entry that is not leaving this
  // cycle, a held skid entry, and a fetch accepted in the same cycle.
  assign n_disc  = {1'b0, main_valid & ~out_xfer} + {1'b0, skid_valid} + {1'b0, in_xfer};
  assign cnt_sum = {2'b00, cnt_desc} + {{ANCHO_CNT{1'b0}}, n_disc};

  always_comb begin
    main_valid_n = main_valid;
    main_addr_n  = main_addr;
    main_inst_n  = main_inst;
    skid_valid_n = skid_valid;
    skid_addr_n  = skid_addr;
    skid_inst_n  = skid_inst;
    cnt_n        = cnt_desc;

    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      cnt_n        = (cnt_sum > CNT_MAX) ? CNT_MAX[ANCHO_CNT-1:0] : cnt_sum[ANCHO_CNT-1:0];
    end else if (!main_valid) begin
      // Skid is never valid while main is empty.
      if (in_xfer) begin
        main_valid_n = 1'b1;
        main_addr_n  = EnAdd;
        main_inst_n  = EnInsM;
      end
    end else if (!skid_valid) begin
      if (in_xfer && out_xfer) begin
        main_addr_n = EnAdd;
        main_inst_n = EnInsM;
      end else if (in_xfer) begin
        skid_valid_n = 1'b1;
        skid_addr_n  = EnAdd;
        skid_inst_n  = EnInsM;
      end else if (out_xfer) begin
        // SalBuf keeps its last value; SalInst falls back to INST_NOP.
        main_valid_n = 1'b0;
      end
    end else begin
      // Both full: en_ready is low so no input can arrive here.
      if (out_xfer) begin
        main_addr_n  = skid_addr;
        main_inst_n  = skid_inst;
        skid_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_addr  <= '0;
      main_inst  <= INST_NOP;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_inst  <= INST_NOP;
      en_ready   <= 1'b1;
      ocupacion  <= 2'd0;
      cnt_desc   <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_addr  <= main_addr_n;
      main_inst  <= main_inst_n;
      skid_valid <= skid_valid_n;
      skid_addr  <= skid_addr_n;
      skid_inst  <= skid_inst_n;
      en_ready   <= ~skid_valid_n;
      ocupacion  <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
      cnt_desc   <= cnt_n;
    end
  end

  assign sal_valid = main_valid;
  assign SalBuf    = main_addr;
  assign SalInst   = main_valid ? main_inst : INST_NOP;

endmodule

// File: tb/tb_bufer_if_id_skid.sv
// Directed testbench for bufer_if_id_skid (instantiated with ANCHO_CNT=2 so
// counter saturation is reachable). Inputs change 1 time unit after a rising
// edge; outputs are checked 1 time unit after the following rising edge.
module tb_bufer_if_id_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_valid, en_ready;
  logic [31:0] EnAdd, EnInsM;
  logic        stall, flush, sal_ready, sal_valid;
  logic [31:0] SalBuf, SalInst;
  logic [1:0]  ocupacion;
  logic [1:0]  cnt_desc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ins_tab [3] = '{32'h20080005, 32'h20090003, 32'h01095020};

  bufer_if_id_skid #(
    .ANCHO_DIR (32),
    .ANCHO_INST(32),
    .INST_NOP  (32'h00000000),
    .ANCHO_CNT (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_valid (en_valid),
    .en_ready (en_ready),
    .EnAdd    (EnAdd),
    .EnInsM   (EnInsM),
    .stall    (stall),
    .flush    (flush),
    .sal_ready(sal_ready),
    .sal_valid(sal_valid),
    .SalBuf   (SalBuf),
    .SalInst  (SalInst),
    .ocupacion(ocupacion),
    .cnt_desc (cnt_desc)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i);
    en_valid = v;
    EnAdd    = a;
    EnInsM   = i;
  endtask

  // Fill main + skid with two fetches while ID is not ready.
  task automatic fill2(input logic [31:0] a1, input logic [31:0] a2);
    sal_ready = 1'b0;
    drive(1'b1, a1, 32'h1000_0000 | a1);
    step();
    drive(1'b1, a2, 32'h1000_0000 | a2);
    step();
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'b0, sal_valid}, 32'd0);
    check({tag, "_inst"},  SalInst, 32'h0);
    check({tag, "_ocup"},  {30'b0, ocupacion}, 32'd0);
    check({tag, "_ready"}, {31'b0, en_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; sal_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    step();
    step();
    rst = 1'b0;
    check_empty("rst");
    check("rst_buf", SalBuf, 32'd0);
    check("rst_cnt", {30'b0, cnt_desc}, 32'd0);

    // 1: streaming with 1-cycle latency
    sal_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(4 * (k + 1)), ins_tab[k]);
      step();
      check("s1_valid", {31'b0, sal_valid}, 32'd1);
      check("s1_buf",   SalBuf, 32'(4 * (k + 1)));
      check("s1_inst",  SalInst, ins_tab[k]);
      check("s1_ready", {31'b0, en_ready}, 32'd1);
      check("s1_ocup",  {30'b0, ocupacion}, 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check_empty("s1_drain");
    check("s1_bufhold", SalBuf, 32'd12);

    // 2: back-pressure fills the skid, release drains in order
    sal_ready = 1'b0;
    drive(1'b1, 32'd4, ins_tab[0]);
    step();
    check("s2_buf1",   SalBuf, 32'd4);
    check("s2_ocup1",  {30'b0, ocupacion}, 32'd1);
    check("s2_ready1", {31'b0, en_ready}, 32'd1);
    drive(1'b1, 32'd8, ins_tab[1]);
    step();
    check("s2_buf2",   SalBuf, 32'd4);
    check("s2_inst2",  SalInst, ins_tab[0]);
    check("s2_ocup2",  {30'b0, ocupacion}, 32'd2);
    check("s2_ready2", {31'b0, en_ready}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    sal_ready = 1'b1;
    step();
    check("s2_buf3",   SalBuf, 32'd8);
    check("s2_inst3",  SalInst, ins_tab[1]);
    check("s2_ocup3",  {30'b0, ocupacion}, 32'd1);
    check("s2_ready3", {31'b0, en_ready}, 32'd1);
    step();
    check_empty("s2_end");

    // 3: stall freezes a full buffer without loss
    fill2(32'd16, 32'd20);
    sal_ready = 1'b1;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("s3_buf",   SalBuf, 32'd16);
      check("s3_inst",  SalInst, 32'h1000_0010);
      check("s3_ocup",  {30'b0, ocupacion}, 32'd2);
      check("s3_ready", {31'b0, en_ready}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("s3_buf_a",  SalBuf, 32'd20);
    check("s3_inst_a", SalInst, 32'h1000_0014);
    check("s3_ocup_a", {30'b0, ocupacion}, 32'd1);
    step();
    check_empty("s3_end");

    // 4: flush with main+skid full and a refused input -> discards 2
    fill2(32'd24, 32'd28);
    check("s4_cnt0", {30'b0, cnt_desc}, 32'd0);
    drive(1'b1, 32'd32, 32'hDEAD_BEEF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_empty("s4_flush");
    check("s4_cnt", {30'b0, cnt_desc}, 32'd2);
    step();
    check("s4_noaccept", {31'b0, sal_valid}, 32'd0);

    // 5: saturation with a 2-bit counter, then rst beats flush
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s5_cnt0", {30'b0, cnt_desc}, 32'd0);
    sal_ready = 1'b0;
    drive(1'b1, 32'd36, 32'h0000_0036);
    step();
    // main leaves in the flush cycle (not counted), new input is counted
    sal_ready = 1'b1;
    drive(1'b1, 32'd40, 32'h0000_0040);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("s5_cnt1", {30'b0, cnt_desc}, 32'd1);
    check_empty("s5_f1");
    fill2(32'd44, 32'd48);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("s5_cnt3", {30'b0, cnt_desc}, 32'd3);
    fill2(32'd52, 32'd56);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("s5_sat", {30'b0, cnt_desc}, 32'd3);
    sal_ready = 1'b0;
    drive(1'b1, 32'd60, 32'h0000_0060);
    step();
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    check("s5_rcnt", {30'b0, cnt_desc}, 32'd0);
    check_empty("s5_rst");
    check("s5_rbuf", SalBuf, 32'd0);

    // 6: reset mid-stream with the buffer full, then 1-cycle latency again
    fill2(32'd64, 32'd68);
    check("s6_ocup", {30'b0, ocupacion}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_empty("s6_rst");
    check("s6_buf", SalBuf, 32'd0);
    sal_ready = 1'b1;
    drive(1'b1, 32'd72, ins_tab[2]);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("s6_valid", {31'b0, sal_valid}, 32'd1);
    check("s6_buf2",  SalBuf, 32'd72);
    check("s6_inst2", SalInst, ins_tab[2]);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bufer_if_id_skid.md
Name: bufer_if_id_skid

Overview:
Parametrised IF/ID pipeline register, the successor to the fixed 32-bit IF/ID latch. It carries the fetch PC+4 and the instruction from the IF stage to the ID stage.
- Adds valid/ready handshaking, a 2-entry skid buffer, hazard-unit stall, branch flush that injects a NOP bubble, and a saturating discard counter.
- Sits between the instruction memory/PC adder and the decode/register-file stage.

Parameters:
- ANCHO_DIR, 32, width of the PC/address field.
- ANCHO_INST, 32, width of the instruction field.
- INST_NOP, 32'h00000000, instruction value presented when the output is not valid or has been flushed. Width is ANCHO_INST.
- ANCHO_CNT, 8, width of the flush-discard counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en_valid, input, 1, the IF stage presents a fetch.
- en_ready, output, 1, the buffer can accept a fetch. Registered.
- EnAdd, input, ANCHO_DIR, PC+4 from the IF adder.
- EnInsM, input, ANCHO_INST, instruction from instruction memory.
- stall, input, 1, hazard-unit hold of the ID stage.
- flush, input, 1, branch/jump taken: discard everything held and in flight.
- sal_ready, input, 1, the ID stage can consume.
- sal_valid, output, 1, SalBuf/SalInst carry a real fetch.
- SalBuf, output, ANCHO_DIR, PC+4 to ID.
- SalInst, output, ANCHO_INST, instruction to ID.
- ocupacion, output, 2, number of entries held (0..2).
- cnt_desc, output, ANCHO_CNT, count of valid fetches discarded by flush. Saturating.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values:
  - sal_valid=0, SalBuf=0, SalInst=INST_NOP.
  - en_ready=1, ocupacion=0, cnt_desc=0.
  - Skid entry invalid.
  - rst has priority over flush, stall and all transfers.
- Storage and control:
  - Storage is a main (output) entry plus one skid entry.
  - Input transfer: en_valid & en_ready.
  - Output transfer: sal_valid & sal_ready & ~stall. stall is equivalent to sal_ready=0.
- Latency:
  - An accepted fetch appears on SalBuf/SalInst with sal_valid=1 one cycle after acceptance when the main entry is free or being consumed.
  - Order is strictly preserved.
- Non-flush update rules, by state:
  - Empty + input: write main.
  - Main only, output transfer + input: overwrite main with the new fetch.
  - Main only, no output transfer + input: write skid.
  - Main only, output transfer, no input: main becomes invalid. SalInst returns to INST_NOP and SalBuf holds its last value.
  - Main+skid, output transfer: skid moves to main and skid becomes invalid. en_ready=0 in this state, so no input is possible.
  - Main+skid, no output transfer: hold.
- Combined register behaviour:
  - en_ready is the registered value of ~skid_valid_next.
  - It falls in the cycle after the skid fills and rises in the cycle after the skid drains.
  - The buffer never drops a fetch and never accepts one while en_ready=0.
- While sal_valid=0, SalInst=INST_NOP so that decode sees a bubble regardless of sal_valid usage.
- flush=1 (without rst), same edge:
  - Main and skid become invalid, SalInst=INST_NOP, sal_valid=0.
  - en_ready=1, ocupacion=0.
  - Any input transfer in that cycle is discarded.
  - cnt_desc increments by the number of valid entries discarded: held main + held skid + accepted input, 0..3 per cycle.
  - cnt_desc saturates at 2^ANCHO_CNT-1 with no wrap.
  - An output transfer in the flush cycle still counts as consumed, so that entry is not counted.
- flush overrides stall. stall has no effect on input acceptance while the skid is free.
- ocupacion = main_valid + skid_valid, registered. It is consistent with sal_valid (ocupacion≥1 ⇔ sal_valid=1).
- en_valid is not required to be held by the source when en_ready=0. The buffer does not sample in that case.

Test Plan:
1. Reset, then present a stream with en_valid=1, sal_ready=1: EnAdd=4,8,12 with EnInsM=0x20080005, 0x20090003, 0x01095020.
   -> Each appears on the next cycle with sal_valid=1. en_ready stays 1. ocupacion=1.
2. Hold sal_ready=0 while presenting EnAdd=4 then 8.
   -> Cycle 1: main=4. Cycle 2: skid=8, en_ready drops to 0 next cycle, ocupacion=2.
   -> Release sal_ready: 4 then 8 in order. en_ready returns to 1 one cycle after the skid drains.
3. stall=1 for 3 cycles with main+skid full and sal_ready=1.
   -> SalBuf/SalInst frozen for 3 cycles with no loss.
   -> After release, correct order and no duplicate.
4. Main+skid full and en_valid=1, pulse flush=1 for one cycle.
   -> Next cycle: sal_valid=0, SalInst=0x00000000, ocupacion=0, en_ready=1.
   -> cnt_desc increases by 2; the input was not accepted because en_ready=0.
5. With ANCHO_CNT=2, issue flushes that discard 5 valid fetches in total.
   -> cnt_desc stops at 3.
   -> rst=1 asserted together with flush -> cnt_desc=0 and all outputs at reset values.
6. Mid-stream, assert rst while ocupacion=2.
   -> Next cycle: sal_valid=0, SalBuf=0, SalInst=INST_NOP, en_ready=1.
   -> The first fetch after deassertion flows with 1-cycle latency.
